// File: rtl/aes_pkg.sv
// aes_pkg: shared block/byte types and collector state encoding
package aes_pkg;
  localparam int BLK_N = 16;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 4;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [BLK_N-1:0] blk_t;
  typedef enum logic [1:0] {COL_EMPTY, COL_FILL, COL_FULL} col_state_t;
endpackage

// File: rtl/mod_reg16_1to16_if.sv
// mod_reg16_1to16_if: byte write, block read and status signals of the collector
interface mod_reg16_1to16_if;
  import aes_pkg::*;
  byte_t i;
  logic wr_en;
  logic wr_rdy;
  logic clr;
  logic rd_en;
  blk_t o;
  logic reg_full;
  logic reg_empty;
  logic [CNT_W-1:0] n_wr;
  modport master (output i, wr_en, clr, rd_en, input wr_rdy, o, reg_full, reg_empty, n_wr);
  modport slave (input i, wr_en, clr, rd_en, output wr_rdy, o, reg_full, reg_empty, n_wr);
endinterface

// File: rtl/mod_reg16_1to16.sv
// mod_reg16_1to16: collects 16 bytes one per handshake into a parallel 128-bit block
module mod_reg16_1to16
  import aes_pkg::*;
(
  input logic clk,
  input logic resetn,
  mod_reg16_1to16_if.slave s_if
);
  col_state_t r_state;
  col_state_t w_nxt;
  logic [CNT_W-1:0] r_n_wr;
  blk_t r_o;
  logic r_full;
  logic r_empty;
  logic w_acc;
  logic w_rd;
  // A release in the same cycle frees the slot, so a full block never stalls the stream
  assign s_if.wr_rdy = (r_state != COL_FULL) | s_if.rd_en;
  assign w_acc = s_if.wr_en & s_if.wr_rdy & ~s_if.clr;
  assign w_rd = s_if.rd_en & (r_state == COL_FULL);
  always_comb begin
    w_nxt = s_if.clr ? COL_EMPTY :
            (w_acc & (r_n_wr == CNT_W'(BLK_N-1))) ? COL_FULL :
            w_acc ? COL_FILL :
            w_rd ? COL_EMPTY : r_state;
  end
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= COL_EMPTY;
      r_n_wr <= '0;
      r_o <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_full <= (w_nxt == COL_FULL);
      r_empty <= (w_nxt == COL_EMPTY);
      r_n_wr <= s_if.clr ? '0 : r_n_wr + CNT_W'(w_acc);
      if (w_acc) r_o[r_n_wr] <= s_if.i;
    end
  end
  assign s_if.o = r_o;
  assign s_if.reg_full = r_full;
  assign s_if.reg_empty = r_empty;
  assign s_if.n_wr = r_n_wr;
endmodule

// File: tb/tb_mod_reg16_1to16.sv
// tb_mod_reg16_1to16: directed checks of the byte-to-block collector
module tb_mod_reg16_1to16;
  import aes_pkg::*;
  logic clk;
  logic resetn;
  int n_assert;
  int n_fail;
  blk_t exp_o;
  blk_t blk_a;
  blk_t blk_b;
  mod_reg16_1to16_if bus ();
  mod_reg16_1to16 dut (.clk(clk), .resetn(resetn), .s_if(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    n_assert = 0;
    n_fail = 0;
    resetn = 1'b1;
    bus.i = '0;
    bus.wr_en = 1'b0;
    bus.clr = 1'b0;
    bus.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    chk("rst_empty", bus.reg_empty, 1);
    chk("rst_full", bus.reg_full, 0);
    chk("rst_nwr", bus.n_wr, 0);
    chk("rst_o", bus.o, 0);
    chk("rst_rdy", bus.wr_rdy, 1);
    for (int k = 0; k < 16; k++) begin
      bus.i = byte_t'(k);
      bus.wr_en = 1'b1;
      tick();
      if (k == 6) begin
        chk("fill_nwr7", bus.n_wr, 7);
        chk("fill_state", {bus.reg_full, bus.reg_empty}, 2'b00);
      end
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 16; k++) exp_o[k] = byte_t'(k);
    chk("full_flag", bus.reg_full, 1);
    chk("full_empty", bus.reg_empty, 0);
    chk("full_nwr", bus.n_wr, 0);
    chk("full_o", bus.o, exp_o);
    chk("full_rdy", bus.wr_rdy, 0);
    bus.i = 8'hAA;
    bus.wr_en = 1'b1;
    repeat (5) tick();
    chk("hold_o", bus.o, exp_o);
    chk("hold_nwr", bus.n_wr, 0);
    chk("hold_full", bus.reg_full, 1);
    chk("hold_rdy", bus.wr_rdy, 0);
    bus.i = 8'h5A;
    bus.rd_en = 1'b1;
    #1;
    chk("rdacc_rdy", bus.wr_rdy, 1);
    tick();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    exp_o[0] = 8'h5A;
    chk("rdacc_full", bus.reg_full, 0);
    chk("rdacc_empty", bus.reg_empty, 0);
    chk("rdacc_nwr", bus.n_wr, 1);
    chk("rdacc_o", bus.o, exp_o);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("rd_fill_ign", {bus.reg_full, bus.n_wr}, 5'b0_0001);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_empty", {bus.reg_empty, bus.n_wr}, 5'b1_0000);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("rd_empty_ign", {bus.reg_full, bus.reg_empty}, 2'b01);
    for (int k = 0; k < 7; k++) begin
      bus.i = byte_t'(8'h30 + k);
      bus.wr_en = 1'b1;
      tick();
      exp_o[k] = byte_t'(8'h30 + k);
    end
    chk("pre_clr_nwr", bus.n_wr, 7);
    bus.i = 8'hEE;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.wr_en = 1'b0;
    chk("clr_nwr", bus.n_wr, 0);
    chk("clr_flags", {bus.reg_full, bus.reg_empty}, 2'b01);
    chk("clr_o", bus.o, exp_o);
    for (int k = 0; k < 9; k++) begin
      bus.i = byte_t'(8'h40 + k);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    chk("pre_arst_nwr", bus.n_wr, 9);
    #3;
    resetn = 1'b1;
    #1;
    chk("arst_nwr", bus.n_wr, 0);
    chk("arst_empty", bus.reg_empty, 1);
    chk("arst_o", bus.o, 0);
    #1;
    resetn = 1'b0;
    tick();
    blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_b = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    for (int k = 0; k < 16; k++) begin
      bus.i = blk_a[k];
      bus.wr_en = 1'b1;
      tick();
    end
    chk("rt_a_full", bus.reg_full, 1);
    chk("rt_a_o", bus.o, blk_a);
    for (int k = 0; k < 16; k++) begin
      bus.i = blk_b[k];
      bus.rd_en = (k == 0);
      #1;
      chk("rt_b_rdy", bus.wr_rdy, 1);
      tick();
      if (k == 0) chk("rt_b_first", {bus.reg_full, bus.n_wr}, 5'b0_0001);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("rt_b_full", bus.reg_full, 1);
    chk("rt_b_o", bus.o, blk_b);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("rel_flags", {bus.reg_full, bus.reg_empty}, 2'b01);
    chk("rel_o_kept", bus.o, blk_b);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
